cmd_uart_initiator: RTL and testbench

CMD_UART_INITIATOR -- requirements
Module: cmd_uart_initiator

---
 rtl/cmd_uart_initiator_pkg.sv | 17 +
 rtl/cmd_uart_initiator_ack_rx.sv | 92 +++++++++
 rtl/cmd_uart_initiator.sv | 166 ++++++++++++++++
 tb/tb_cmd_uart_initiator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_uart_initiator_pkg.sv
// Purpose : shared constants and FSM state type for the command UART initiator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package cmd_uart_initiator_pkg;

  localparam logic [7:0] ACK_CHAR   = 8'h41;  // 'A' returned by the vehicle on success
  localparam int         FRAME_BITS = 11;     // start + 8 data + 2 stop
  localparam int         CMD_BYTES  = 3;      // lmotor, rmotor, dur

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    FINISH
  } state_t;

endpackage

// File: rtl/cmd_uart_initiator_ack_rx.sv
// Purpose : ack receiver -- 2-flop rx synchronizer, mid-bit sampler, byte/stop check.
// Latency : byte_valid/byte_good pulse the cycle after the mid-stop-bit sample.
// Backpressure: none; i_en low aborts any reception and holds the receiver idle.
//
// Ports: clk, reset (sync, active high); i_en (receive window open); i_rx (async line);
//        byte_valid (1-cycle pulse, byte finished), byte_good (qualifies byte_valid:
//        ACK_CHAR with stop=1), rx_busy (reception in progress).
module ack_rx
  import cmd_uart_initiator_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_rx,
  output logic byte_valid,
  output logic byte_good,
  output logic rx_busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1, r_sync2;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;    // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    r_shift;
  logic          r_valid, r_good;
  logic          w_rxs;

  assign w_rxs      = r_sync2;
  assign byte_valid = r_valid;
  assign byte_good  = r_good;
  assign rx_busy    = r_busy;

  // Synchronizer runs regardless of i_en so the line is already settled when the window opens.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_good  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_good  <= 1'b0;
      if (!r_busy) begin
        if (!w_rxs) begin
          r_busy <= 1'b1;
          r_cnt  <= '0;
          r_bit  <= '0;
        end
      end else if (r_bit == 4'd0) begin
        // Re-check the start bit half a bit after the falling edge; high means a glitch.
        if (r_cnt == HALF_LAST) begin
          r_cnt <= '0;
          if (w_rxs) r_busy <= 1'b0;
          else       r_bit  <= 4'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_cnt == BIT_LAST) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_good  <= (r_shift == ACK_CHAR) && w_rxs;
        end else begin
          r_shift <= {r_shift[6:0], w_rxs};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_uart_initiator.sv
// Purpose : sends a 3-byte motor command over UART, waits for an 'A' ack, retries on bad ack/timeout.
// Latency : tx start bit the cycle after start is accepted; SEND lasts 33*CLKS_PER_BIT cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
//
// Ports: clk, reset (sync, active high); start, lmotor/rmotor/dur (command request);
//        rx (ack line); tx (command line, idle high); busy, done (1-cycle), ack_ok/fail
//        (sticky result), attempts (attempts used minus one).
module cmd_uart_initiator
  import cmd_uart_initiator_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int ACK_TIMEOUT  = 4096,
  parameter int MAX_RETRIES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] lmotor,
  input  logic [7:0] rmotor,
  input  logic [7:0] dur,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       fail,
  output logic [1:0] attempts
);

  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam int            TW         = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    FRAME_LAST = 4'(FRAME_BITS - 1);
  localparam logic [1:0]    BYTE_LAST  = 2'(CMD_BYTES - 1);
  localparam logic [1:0]    RETRY_MAX  = 2'(MAX_RETRIES);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_lm, r_rm, r_dur;
  logic [CW-1:0] r_clk_cnt;
  logic [3:0]    r_bit_idx;
  logic [1:0]    r_byte_idx;
  logic [TW-1:0] r_to_cnt;
  logic [1:0]    r_attempts;
  logic          r_ack_ok, r_fail;

  logic       w_accept, w_retry, w_good, w_giveup;
  logic       w_bit_end, w_frame_end, w_timeout;
  logic       w_rx_en, w_byte_valid, w_byte_good, w_rx_busy;
  logic [7:0] w_cur_byte;

  assign ack_ok   = r_ack_ok;
  assign fail     = r_fail;
  assign attempts = r_attempts;
  assign w_rx_en  = (r_state == WAIT_ACK);

  ack_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ack_rx (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_rx_en),
    .i_rx       (rx),
    .byte_valid (w_byte_valid),
    .byte_good  (w_byte_good),
    .rx_busy    (w_rx_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_retry     = 1'b0;
    w_good      = 1'b0;
    w_giveup    = 1'b0;
    w_bit_end   = (r_clk_cnt == BIT_LAST);
    w_frame_end = w_bit_end && (r_bit_idx == FRAME_LAST);
    // A reception already under way at the deadline is allowed to decide the attempt.
    w_timeout   = (r_to_cnt == TO_LAST) && !w_rx_busy;
    case (r_state)
      IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: if (w_frame_end && (r_byte_idx == BYTE_LAST)) w_state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (w_byte_valid && w_byte_good) begin
          w_good      = 1'b1;
          w_state_nxt = FINISH;
        end else if (w_byte_valid || w_timeout) begin
          if (r_attempts < RETRY_MAX) begin
            w_retry     = 1'b1;
            w_state_nxt = SEND;
          end else begin
            w_giveup    = 1'b1;
            w_state_nxt = FINISH;
          end
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    busy = (r_state != IDLE);
    done = (r_state == FINISH);
    case (r_byte_idx)
      2'd1:    w_cur_byte = r_rm;
      2'd2:    w_cur_byte = r_dur;
      default: w_cur_byte = r_lm;
    endcase
    // Frame bit 0 is the start bit, 1..8 carry data MSB first, 9..10 are stop bits.
    tx = 1'b1;
    if (r_state == SEND) begin
      if (r_bit_idx == 4'd0)      tx = 1'b0;
      else if (r_bit_idx <= 4'd8) tx = w_cur_byte[3'(4'd8 - r_bit_idx)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lm       <= '0;
      r_rm       <= '0;
      r_dur      <= '0;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_to_cnt   <= '0;
      r_attempts <= '0;
      r_ack_ok   <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      case (r_state)
        SEND: begin
          r_to_cnt  <= '0;
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
          if (w_bit_end)   r_bit_idx  <= w_frame_end ? 4'd0 : r_bit_idx + 4'd1;
          if (w_frame_end) r_byte_idx <= r_byte_idx + 2'd1;
        end
        WAIT_ACK: if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
        default: ;
      endcase
      if (w_accept) begin
        r_lm       <= lmotor;
        r_rm       <= rmotor;
        r_dur      <= dur;
        r_ack_ok   <= 1'b0;
        r_fail     <= 1'b0;
        r_attempts <= '0;
        r_clk_cnt  <= '0;
        r_bit_idx  <= '0;
        r_byte_idx <= '0;
      end
      if (w_retry) begin
        r_attempts <= r_attempts + 2'd1;
        r_clk_cnt  <= '0;
        r_bit_idx  <= '0;
        r_byte_idx <= '0;
      end
      if (w_good)   r_ack_ok <= 1'b1;
      if (w_giveup) r_fail   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_uart_initiator.sv
// Purpose : directed self-checking bench for cmd_uart_initiator.
// Latency : n/a.
// Backpressure: n/a.
module tb_cmd_uart_initiator;

  localparam int CPB = 8;
  localparam int TO  = 400;
  localparam int MR  = 2;

  logic       clk = 1'b0;
  logic       reset, start, rx;
  logic [7:0] lmotor, rmotor, dur;
  logic       tx, busy, done, ack_ok, fail;
  logic [1:0] attempts;

  int n_total  = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  cmd_uart_initiator #(
    .CLKS_PER_BIT (CPB),
    .ACK_TIMEOUT  (TO),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lmotor   (lmotor),
    .rmotor   (rmotor),
    .dur      (dur),
    .rx       (rx),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .ack_ok   (ack_ok),
    .fail     (fail),
    .attempts (attempts)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ack_ok === 1'b1 && fail === 1'b1) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one ack byte on rx: start bit then 8 data bits MSB first; line is left high,
  // which serves as the stop bit.
  task automatic send_rx(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 7; i >= 0; i--) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = 1'b1;
  endtask

  // Wait for a start bit on tx, then check every cycle of the 33 bits against the bytes.
  task automatic expect_triplet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input string tag, output int waited);
    logic [7:0] bytes [3];
    int         bad;
    int         pos;
    logic       e;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    waited   = 0;
    bad      = 0;
    while (tx !== 1'b0 && waited < 5000) begin
      tick();
      waited++;
    end
    chk({tag, "_found"}, 32'(waited < 5000), 32'd1);
    if (waited >= 5000) return;
    for (int b = 0; b < 33; b++) begin
      pos = b % 11;
      if (pos == 0)      e = 1'b0;
      else if (pos <= 8) e = bytes[b / 11][8 - pos];
      else               e = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== e) bad++;
        tick();
      end
    end
    chk({tag, "_bits"}, 32'(bad), 32'd0);
    chk({tag, "_wait_tx_busy"}, 32'({tx, busy}), 32'h3);
  endtask

  task automatic wait_done(input string tag, input int bound, output int waited);
    waited = 0;
    while (done !== 1'b1 && waited < bound) begin
      tick();
      waited++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int w;
    int d0;

    reset = 1'b1; start = 1'b0; rx = 1'b1;
    lmotor = 8'h00; rmotor = 8'h00; dur = 8'h00;
    repeat (3) tick();
    chk("rst_tx",       32'(tx),       32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ack_ok",   32'(ack_ok),   32'd0);
    chk("rst_fail",     32'(fail),     32'd0);
    chk("rst_attempts", 32'(attempts), 32'd0);
    reset = 1'b0;
    tick();

    // Good ack on first attempt.
    lmotor = 8'h95; rmotor = 8'hB6; dur = 8'h35; d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_start_bit", 32'(tx),   32'd0);
    chk("t1_busy",      32'(busy), 32'd1);
    expect_triplet(8'h95, 8'hB6, 8'h35, "t1", w);
    chk("t1_latency", 32'(w), 32'd0);
    repeat (10) tick();
    send_rx(8'h41);
    wait_done("t1", 200, w);
    chk("t1_ack_latency", 32'(w), 32'd8);
    tick();
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_ack_ok",    32'(ack_ok),        32'd1);
    chk("t1_fail",      32'(fail),          32'd0);
    chk("t1_attempts",  32'(attempts),      32'd0);
    chk("t1_idle",      32'({busy, done}),  32'd0);

    // No ack at all: three identical triplets, then fail. Inputs change after accept.
    lmotor = 8'h01; rmotor = 8'h80; dur = 8'hFF; d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    lmotor = 8'h00; rmotor = 8'h00; dur = 8'h00;
    chk("t2_ack_cleared", 32'(ack_ok), 32'd0);
    expect_triplet(8'h01, 8'h80, 8'hFF, "t2a", w);
    chk("t2a_att", 32'(attempts), 32'd0);
    expect_triplet(8'h01, 8'h80, 8'hFF, "t2b", w);
    chk("t2b_gap", 32'(w),        32'(TO));
    chk("t2b_att", 32'(attempts), 32'd1);
    expect_triplet(8'h01, 8'h80, 8'hFF, "t2c", w);
    chk("t2c_gap", 32'(w),        32'(TO));
    chk("t2c_att", 32'(attempts), 32'd2);
    wait_done("t2", TO + 50, w);
    chk("t2_done_gap", 32'(w), 32'(TO));
    tick();
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t2_fail",      32'(fail),          32'd1);
    chk("t2_ack_ok",    32'(ack_ok),        32'd0);
    chk("t2_attempts",  32'(attempts),      32'd2);

    // Bad ack then good ack.
    lmotor = 8'h7F; rmotor = 8'h00; dur = 8'hC3; d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_fail_cleared", 32'(fail), 32'd0);
    expect_triplet(8'h7F, 8'h00, 8'hC3, "t3a", w);
    repeat (5) tick();
    send_rx(8'h42);
    expect_triplet(8'h7F, 8'h00, 8'hC3, "t3b", w);
    chk("t3_retry_gap", 32'(w),        32'd8);
    chk("t3_att",       32'(attempts), 32'd1);
    repeat (3) tick();
    send_rx(8'h41);
    wait_done("t3", 200, w);
    tick();
    chk("t3_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t3_ack_ok",    32'(ack_ok),        32'd1);
    chk("t3_fail",      32'(fail),          32'd0);
    chk("t3_attempts",  32'(attempts),      32'd1);

    // One-cycle low glitch is discarded, then a valid ack.
    lmotor = 8'hAA; rmotor = 8'h55; dur = 8'h0F; d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    expect_triplet(8'hAA, 8'h55, 8'h0F, "t4", w);
    repeat (4) tick();
    rx = 1'b0; tick(); rx = 1'b1;
    repeat (20) tick();
    chk("t4_still_waiting", 32'({busy, tx}), 32'h3);
    chk("t4_no_retry",      32'(attempts),   32'd0);
    send_rx(8'h41);
    wait_done("t4", 200, w);
    chk("t4_ack_latency", 32'(w), 32'd8);
    tick();
    chk("t4_ack_ok",   32'(ack_ok),   32'd1);
    chk("t4_attempts", 32'(attempts), 32'd0);

    // start held high throughout: only one command until done.
    lmotor = 8'h12; rmotor = 8'h34; dur = 8'h56;
    start = 1'b1; tick();
    d0 = done_cnt;
    expect_triplet(8'h12, 8'h34, 8'h56, "t5", w);
    repeat (2) tick();
    send_rx(8'h41);
    wait_done("t5", 200, w);
    chk("t5_attempts", 32'(attempts), 32'd0);
    tick();
    chk("t5_idle_gap",  32'(busy),          32'd0);
    chk("t5_done_once", 32'(done_cnt - d0), 32'd1);
    tick();
    chk("t5_restart", 32'({busy, tx}), 32'h2);
    start = 1'b0;

    // Reset in the middle of the second byte of the restarted command.
    repeat (132) tick();
    d0 = done_cnt;
    chk("t6_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_tx_high", 32'(tx),   32'd1);
    chk("t6_busy",    32'(busy), 32'd0);
    repeat (300) tick();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_idle",    32'({busy, tx}),    32'h1);
    chk("t6_ack_ok",  32'(ack_ok),        32'd0);

    // Normal command after the reset.
    lmotor = 8'h00; rmotor = 8'hFF; dur = 8'h81; d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    chk("t7_start_bit", 32'(tx), 32'd0);
    expect_triplet(8'h00, 8'hFF, 8'h81, "t7", w);
    send_rx(8'h41);
    wait_done("t7", 200, w);
    tick();
    chk("t7_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t7_ack_ok",    32'(ack_ok),        32'd1);

    chk("never_ack_and_fail", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
